// File: rtl/tracker_ctrl.sv
// Test sequencer driving the tracker: start/warm-up/run/drain/done flow with
// EOT mailbox sniffing, RUN timeout, and sticky pass/fail/timeout reporting.
module tracker_ctrl #(
  parameter int          CYCLE_CNT_W    = 32,
  parameter logic [31:0] EOT_ADDR       = 32'h0000_1000,
  parameter int          TRACK_DELAY    = 0,
  parameter int          DRAIN_CYCLES   = 4,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   eot_wr_en,
  input  logic [31:0]            eot_wr_addr,
  input  logic [31:0]            eot_wr_data,
  output logic                   trigger,
  output logic                   test_undone,
  output logic [CYCLE_CNT_W-1:0] cycle_count,
  output logic                   enable,
  output logic                   test_pass,
  output logic                   test_fail,
  output logic                   test_timeout,
  output logic [30:0]            eot_code
);

  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [31:0] L_TD    = 32'(TRACK_DELAY);
  localparam logic [31:0] L_DC    = 32'(DRAIN_CYCLES);
  localparam logic [31:0] L_TO_M1 = 32'(TIMEOUT_CYCLES - 1);
  localparam state_t      L_POST  = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;

  state_t                 r_state, w_nxt;
  logic [31:0]            r_cnt, w_cnt_nxt;
  logic [31:0]            r_run, w_run_nxt;
  logic                   w_eot, w_hit, w_tmo;
  logic                   r_trigger, r_undone, r_enable;
  logic                   r_pass, r_fail, r_tmo;
  logic [CYCLE_CNT_W-1:0] r_cc;
  logic [30:0]            r_code;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_run_nxt = r_run;
    w_hit     = 1'b0;
    w_tmo     = 1'b0;
    w_eot     = eot_wr_en && (eot_wr_addr == EOT_ADDR);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (TRACK_DELAY == 0) begin
            w_nxt     = S_RUN;
            w_run_nxt = '0;
          end else begin
            w_nxt     = S_WARMUP;
            w_cnt_nxt = L_TD;
          end
        end
      end
      S_WARMUP: begin
        if (w_eot) begin
          w_hit     = 1'b1;
          w_nxt     = L_POST;
          w_cnt_nxt = L_DC;
        end else if (r_cnt <= 32'd1) begin
          w_nxt     = S_RUN;
          w_run_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      S_RUN: begin
        // EOT has priority over a timeout landing on the same edge
        if (w_eot) begin
          w_hit     = 1'b1;
          w_nxt     = L_POST;
          w_cnt_nxt = L_DC;
        end else if (r_run == L_TO_M1) begin
          w_tmo     = 1'b1;
          w_nxt     = L_POST;
          w_cnt_nxt = L_DC;
        end else begin
          w_run_nxt = r_run + 32'd1;
        end
      end
      S_DRAIN: begin
        if (r_cnt <= 32'd1) w_nxt = S_DONE;
        else                w_cnt_nxt = r_cnt - 32'd1;
      end
      default: w_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_run     <= '0;
      r_cc      <= '0;
      r_trigger <= 1'b0;
      r_undone  <= 1'b1;
      r_enable  <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_tmo     <= 1'b0;
      r_code    <= '0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= w_cnt_nxt;
      r_run     <= w_run_nxt;
      // outputs are decoded from the next state so they line up with r_state
      r_trigger <= (w_nxt == S_RUN);
      r_enable  <= (w_nxt == S_RUN) || (w_nxt == S_DRAIN);
      r_undone  <= (w_nxt != S_DONE);
      if ((r_state == S_WARMUP || r_state == S_RUN || r_state == S_DRAIN) && (r_cc != '1))
        r_cc <= r_cc + 1'b1;
      if (w_hit) begin
        r_code <= eot_wr_data[31:1];
        if (eot_wr_data == 32'd1) r_pass <= 1'b1;
        else                      r_fail <= 1'b1;
      end
      if (w_tmo) begin
        r_tmo  <= 1'b1;
        r_fail <= 1'b1;
      end
    end
  end

  assign trigger      = r_trigger;
  assign test_undone  = r_undone;
  assign cycle_count  = r_cc;
  assign enable       = r_enable;
  assign test_pass    = r_pass;
  assign test_fail    = r_fail;
  assign test_timeout = r_tmo;
  assign eot_code     = r_code;

endmodule

// File: tb/tb_tracker_ctrl.sv
// Scoreboard bench for tracker_ctrl: directed tests push expected end-of-test
// results; monitors pop and compare when test_undone falls.
module tb_tracker_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic eot_en = 1'b0;
  logic [31:0] eot_addr = '0, eot_data = '0;

  logic trig_a, und_a, en_a, pass_a, fail_a, tmo_a;
  logic [31:0] cc_a;
  logic [30:0] code_a;
  logic trig_b, und_b, en_b, pass_b, fail_b, tmo_b;
  logic [2:0]  cc_b;
  logic [30:0] code_b;

  always #5 clk = ~clk;

  tracker_ctrl #(.CYCLE_CNT_W(32), .EOT_ADDR(32'h1000), .TRACK_DELAY(4),
                 .DRAIN_CYCLES(3), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .eot_wr_en(eot_en),
    .eot_wr_addr(eot_addr), .eot_wr_data(eot_data), .trigger(trig_a),
    .test_undone(und_a), .cycle_count(cc_a), .enable(en_a), .test_pass(pass_a),
    .test_fail(fail_a), .test_timeout(tmo_a), .eot_code(code_a));

  // zero-delay / zero-drain variant with a narrow counter to exercise saturation
  tracker_ctrl #(.CYCLE_CNT_W(3), .EOT_ADDR(32'h1000), .TRACK_DELAY(0),
                 .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .eot_wr_en(eot_en),
    .eot_wr_addr(eot_addr), .eot_wr_data(eot_data), .trigger(trig_b),
    .test_undone(und_b), .cycle_count(cc_b), .enable(en_b), .test_pass(pass_b),
    .test_fail(fail_b), .test_timeout(tmo_b), .eot_code(code_b));

  typedef struct {
    string nm;
    bit    pass, fail, tmo;
    int    code, cc, trg, en;
  } exp_t;

  exp_t qa[$], qb[$];
  int vec = 0, miscompares = 0;
  int nxt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vec++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input bit p, input bit f, input bit t,
                              input int code, input int cc, input int trg, input int en);
    exp_t e;
    e.nm = nm; e.pass = p; e.fail = f; e.tmo = t;
    e.code = code; e.cc = cc; e.trg = trg; e.en = en;
    return e;
  endfunction

  // Monitors: count trigger/enable cycles; compare when DONE is first seen
  initial begin : mon_a
    int ta, ea;
    bit pu;
    exp_t e;
    ta = 0; ea = 0; pu = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ta = 0; ea = 0; pu = 1'b1;
      end else begin
        ta += int'(trig_a);
        ea += int'(en_a);
        if (pu && !und_a) begin
          if (qa.size() == 0) begin
            vec++; miscompares++;
            $display("FAIL a_unexpected_done: got done expected none");
          end else begin
            e = qa.pop_front();
            chk({e.nm, ".pass"}, pass_a, e.pass);
            chk({e.nm, ".fail"}, fail_a, e.fail);
            chk({e.nm, ".timeout"}, tmo_a, e.tmo);
            chk({e.nm, ".code"}, code_a, e.code);
            chk({e.nm, ".cycle_count"}, cc_a, e.cc);
            chk({e.nm, ".trigger_cycles"}, ta, e.trg);
            chk({e.nm, ".enable_cycles"}, ea, e.en);
          end
        end
        pu = und_a;
      end
    end
  end

  initial begin : mon_b
    int ta, ea;
    bit pu;
    exp_t e;
    ta = 0; ea = 0; pu = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ta = 0; ea = 0; pu = 1'b1;
      end else begin
        ta += int'(trig_b);
        ea += int'(en_b);
        if (pu && !und_b) begin
          if (qb.size() == 0) begin
            vec++; miscompares++;
            $display("FAIL b_unexpected_done: got done expected none");
          end else begin
            e = qb.pop_front();
            chk({e.nm, ".pass"}, pass_b, e.pass);
            chk({e.nm, ".fail"}, fail_b, e.fail);
            chk({e.nm, ".timeout"}, tmo_b, e.tmo);
            chk({e.nm, ".code"}, code_b, e.code);
            chk({e.nm, ".cycle_count"}, cc_b, e.cc);
            chk({e.nm, ".trigger_cycles"}, ta, e.trg);
            chk({e.nm, ".enable_cycles"}, ea, e.en);
          end
        end
        pu = und_b;
      end
    end
  end

  // Reset pulse placed away from both clock edges; checks outputs mid-pulse
  task automatic pulse_reset(input string nm);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk({nm, ".trigger"}, trig_a, 0);
    chk({nm, ".undone"}, und_a, 1);
    chk({nm, ".cycle_count"}, cc_a, 0);
    chk({nm, ".enable"}, en_a, 0);
    chk({nm, ".pass"}, pass_a, 0);
    chk({nm, ".fail"}, fail_a, 0);
    chk({nm, ".timeout"}, tmo_a, 0);
    chk({nm, ".code"}, code_a, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // start sampled at edge E; afterwards nxt is the index of the next edge (E+1)
  task automatic pulse_start(input bit b);
    @(negedge clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    nxt = 1;
  endtask

  task automatic advance(input int k);
    repeat (k - nxt) @(negedge clk);
    nxt = k;
  endtask

  // write sampled at edge E+k
  task automatic write_at(input int k, input logic [31:0] a, input logic [31:0] d);
    advance(k);
    eot_en = 1'b1; eot_addr = a; eot_data = d;
    @(negedge clk);
    eot_en = 1'b0; eot_addr = '0; eot_data = '0;
    nxt = k + 1;
  endtask

  task automatic wait_done(input bit b, input string nm);
    for (int i = 0; i < 400; i++) begin
      if ((b ? qb.size() : qa.size()) == 0) break;
      @(negedge clk);
    end
    if ((b ? qb.size() : qa.size()) != 0) begin
      vec++; miscompares++;
      $display("FAIL %s: got no completion expected done within 400 cycles", nm);
      if (b) void'(qb.pop_front()); else void'(qa.pop_front());
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst.trigger", trig_a, 0);
    chk("rst.undone", und_a, 1);
    chk("rst.cycle_count", cc_a, 0);
    chk("rst.enable", en_a, 0);
    chk("rst.flags", {pass_a, fail_a, tmo_a}, 0);
    chk("rst.code", code_a, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // pass: 4 warm-up + 10 run + 3 drain
    qa.push_back(mk("pass", 1, 0, 0, 0, 17, 10, 13));
    pulse_start(1'b0);
    chk("pass.cc_at_start", cc_a, 0);
    advance(2);
    chk("pass.cc_first", cc_a, 1);
    chk("pass.warmup_enable", en_a, 0);
    write_at(14, 32'h1000, 32'h1);
    wait_done(1'b0, "pass.done");

    // fail with code 7>>1 = 3
    pulse_reset("rst2");
    qa.push_back(mk("fail", 0, 1, 0, 3, 12, 5, 8));
    pulse_start(1'b0);
    write_at(9, 32'h1000, 32'h7);
    wait_done(1'b0, "fail.done");

    // timeout after 100 run cycles
    pulse_reset("rst3");
    qa.push_back(mk("timeout", 0, 1, 1, 0, 107, 100, 103));
    pulse_start(1'b0);
    wait_done(1'b0, "timeout.done");

    // EOT on the 100th run cycle beats the timeout
    pulse_reset("rst4");
    qa.push_back(mk("simul", 1, 0, 0, 0, 107, 100, 103));
    pulse_start(1'b0);
    write_at(104, 32'h1000, 32'h1);
    wait_done(1'b0, "simul.done");

    // filtering: IDLE write, wrong address, then a fail hit, later hits ignored
    pulse_reset("rst5");
    eot_en = 1'b1; eot_addr = 32'h1000; eot_data = 32'h1;
    @(negedge clk);
    eot_en = 1'b0;
    chk("filt.idle_write", pass_a, 0);
    qa.push_back(mk("filter", 0, 1, 0, 2, 13, 6, 9));
    pulse_start(1'b0);
    write_at(7, 32'h1004, 32'h1);
    write_at(10, 32'h1000, 32'h5);
    write_at(11, 32'h1000, 32'h1);
    wait_done(1'b0, "filter.done");
    write_at(nxt, 32'h1000, 32'h1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("filt.done_pass", pass_a, 0);
    chk("filt.done_code", code_a, 2);
    chk("filt.done_start", und_a, 0);

    // EOT during warm-up: no trigger, drain still honoured
    pulse_reset("rst6");
    qa.push_back(mk("warmhit", 1, 0, 0, 0, 5, 0, 3));
    pulse_start(1'b0);
    write_at(2, 32'h1000, 32'h1);
    wait_done(1'b0, "warmhit.done");

    // zero delay/drain; 3-bit counter saturates at 7
    pulse_reset("rst7");
    qb.push_back(mk("zero", 1, 0, 0, 0, 7, 9, 9));
    pulse_start(1'b1);
    chk("zero.trigger_after_start", trig_b, 1);
    write_at(9, 32'h1000, 32'h1);
    chk("zero.done_next_edge", und_b, 0);
    wait_done(1'b1, "zero.done");

    // mid-run reset, then a full restart
    pulse_reset("rst8");
    pulse_start(1'b0);
    advance(8);
    chk("midrst.in_run", trig_a, 1);
    pulse_reset("midrst");
    qa.push_back(mk("restart", 1, 0, 0, 0, 17, 10, 13));
    pulse_start(1'b0);
    chk("restart.cc_zero", cc_a, 0);
    advance(2);
    chk("restart.cc_first", cc_a, 1);
    write_at(14, 32'h1000, 32'h1);
    wait_done(1'b0, "restart.done");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

endmodule
